// File: rtl/muldiv_iter_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The master drives requests and kill; the slave returns ready, valid and result.
interface muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_kill;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_kill,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_kill,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with single-cycle shortcuts for divide corner cases.
module muldiv_iter #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  muldiv_iter_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   mag1_q, mag1_d, mag2_q, mag2_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              ready_q, ready_d, valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              signed1, signed2, in_neg1, in_neg2;
  logic              div_zero, div_ovf, fast_mul_req;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, div_step, mul_full, mul_src, mul_signed;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  assign accept = bus.i_valid & ready_q;

  // Request decode: operand signedness and the corner cases that skip iteration.
  always_comb begin
    signed1      = bus.i_op[2] ? ~bus.i_op[0] : (bus.i_op[1:0] != 2'b11);
    signed2      = bus.i_op[2] ? ~bus.i_op[0] : ~bus.i_op[1];
    in_neg1      = signed1 & bus.i_op1[XLEN-1];
    in_neg2      = signed2 & bus.i_op2[XLEN-1];
    div_zero     = bus.i_op[2] & (bus.i_op2 == '0);
    div_ovf      = bus.i_op[2] & ~bus.i_op[0] & (bus.i_op1 == MIN_INT) & (bus.i_op2 == '1);
    fast_mul_req = FAST_MUL & ~bus.i_op[2];
    special_val  = '0;
    if (div_zero)
      special_val = bus.i_op[1] ? bus.i_op1 : '1;
    else if (div_ovf)
      special_val = bus.i_op[1] ? '0 : MIN_INT;
  end

  // One iteration step for each operation, plus the finishing sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mag2_q : {XLEN{1'b0}})};
    mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag2_q};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - mag2_q) : div_shift[XLEN-1:0];
    div_step  = {div_rem, prod_q[XLEN-2:0], div_ge};

    mul_full   = {{XLEN{1'b0}}, mag1_q} * {{XLEN{1'b0}}, mag2_q};
    mul_src    = special_q ? mul_full : prod_q;
    mul_signed = (neg1_q ^ neg2_q) ? -mul_src : mul_src;
    quo_s      = (neg1_q ^ neg2_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_s      = neg1_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

    if (!op_q[2])
      final_res = (op_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];
    else if (special_q)
      final_res = prod_q[XLEN-1:0];
    else
      final_res = op_q[1] ? rem_s : quo_s;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    special_d = special_q;
    mag1_d    = mag1_q;
    mag2_d    = mag2_q;
    prod_d    = prod_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    result_d  = result_q;

    if (bus.i_kill) begin
      state_d = IDLE;
      ready_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          state_d   = CALC;
          ready_d   = 1'b0;
          cnt_d     = '0;
          op_d      = bus.i_op;
          neg1_d    = in_neg1;
          neg2_d    = in_neg2;
          mag1_d    = in_neg1 ? -bus.i_op1 : bus.i_op1;
          mag2_d    = in_neg2 ? -bus.i_op2 : bus.i_op2;
          special_d = div_zero | div_ovf | fast_mul_req;
          prod_d    = {{XLEN{1'b0}},
                       (div_zero | div_ovf) ? special_val : (in_neg1 ? -bus.i_op1 : bus.i_op1)};
        end
        // Shortcut requests spend exactly one CALC cycle before DONE.
        CALC: if (special_q || cnt_q == CW'(XLEN)) begin
          state_d  = DONE;
          valid_d  = 1'b1;
          result_d = final_res;
        end else begin
          prod_d = op_q[2] ? div_step : mul_step;
          cnt_d  = cnt_q + 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      special_q <= 1'b0;
      mag1_q    <= '0;
      mag2_q    <= '0;
      prod_q    <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      special_q <= special_d;
      mag1_q    <= mag1_d;
      mag2_q    <= mag2_d;
      prod_q    <= prod_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  // A kill in the DONE cycle suppresses the pulse without waiting for an edge.
  assign bus.o_valid  = valid_q & ~bus.i_kill;
  assign bus.o_ready  = ready_q;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and randomised checks of muldiv_iter, iterative and fast-multiply builds.
module tb_muldiv_iter;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk, rst;
  int   checks, errors;

  muldiv_iter_if #(.XLEN(32)) bs ();
  muldiv_iter_if #(.XLEN(32)) bf ();

  muldiv_iter #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (.i_clk(clk), .i_rst(rst), .bus(bs));
  muldiv_iter #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (.i_clk(clk), .i_rst(rst), .bus(bf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        p;
    logic signed [31:0] as_, bs_;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'h0, b};
    as_ = a;
    bs_ = b;
    ovf = (a == MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN : 32'(as_ / bs_);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(as_ % bs_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request and waits for the result; lat is edges from accept to o_valid, -1 on timeout.
  task automatic run_op(input bit fast, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!(fast ? bf.o_ready : bs.o_ready) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (fast) begin
      bf.i_valid = 1'b1; bf.i_op = op; bf.i_op1 = a; bf.i_op2 = b;
    end else begin
      bs.i_valid = 1'b1; bs.i_op = op; bs.i_op1 = a; bs.i_op2 = b;
    end
    @(posedge clk); #1;
    bf.i_valid = 1'b0;
    bs.i_valid = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (fast ? bf.o_valid : bs.o_valid) begin
        lat = k;
        res = fast ? bf.o_result : bs.o_result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bs.o_ready !== 1'b1 || bs.o_valid !== 1'b0 || bs.o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_slow got ready=%b valid=%b result=%h expected 1 0 00000000", bs.o_ready, bs.o_valid, bs.o_result);
    end
    checks++;
    if (bf.o_ready !== 1'b1 || bf.o_valid !== 1'b0 || bf.o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_fast got ready=%b valid=%b result=%h expected 1 0 00000000", bf.o_ready, bf.o_valid, bf.o_result);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as_ [4] = '{32'd7, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs_ [4] = '{32'hFFFF_FFFD, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], as_[i], bs_[i], r, lat);
      checks++;
      if (r !== ex[i] || lat != 33) begin
        errors++;
        $display("FAIL mul_%0d got result=%h lat=%0d expected %h lat=33", i, r, lat, ex[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (bs.o_valid !== 1'b0 || bs.o_ready !== 1'b1 || bs.o_result !== ex[i]) begin
        errors++;
        $display("FAIL mul_after_%0d got valid=%b ready=%b result=%h expected 0 1 %h", i, bs.o_valid, bs.o_ready, bs.o_result, ex[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as_ [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs_ [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ops[i], as_[i], bs_[i], r, lat);
      checks++;
      if (r !== ex[i] || lat != 33) begin
        errors++;
        $display("FAIL div_%0d got result=%h lat=%0d expected %h lat=33", i, r, lat, ex[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd7};
    logic [31:0] as_ [5] = '{32'h1234_5678, 32'd5, MIN, MIN, 32'hCAFE_0001};
    logic [31:0] bs_ [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] ex [5] = '{32'hFFFF_FFFF, 32'd5, MIN, 32'h0, 32'hCAFE_0001};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ops[i], as_[i], bs_[i], r, lat);
      checks++;
      if (r !== ex[i] || lat != 1) begin
        errors++;
        $display("FAIL special_%0d got result=%h lat=%0d expected %h lat=1", i, r, lat, ex[i]);
      end
    end
  endtask

  task automatic test_fast_mul();
    logic [31:0] r;
    int lat;
    run_op(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFEB || lat != 1) begin
      errors++;
      $display("FAIL fast_mul got result=%h lat=%0d expected ffffffeb lat=1", r, lat);
    end
    run_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFF || lat != 1) begin
      errors++;
      $display("FAIL fast_mulhsu got result=%h lat=%0d expected ffffffff lat=1", r, lat);
    end
    run_op(1'b1, 3'd4, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFD || lat != 33) begin
      errors++;
      $display("FAIL fast_div got result=%h lat=%0d expected fffffffd lat=33", r, lat);
    end
  endtask

  task automatic test_busy_ignored();
    logic [31:0] r;
    int lat;
    bs.i_valid = 1'b1; bs.i_op = 3'd5; bs.i_op1 = 32'd100; bs.i_op2 = 32'd7;
    @(posedge clk); #1;
    bs.i_op = 3'd0; bs.i_op1 = 32'd3; bs.i_op2 = 32'd3;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bs.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b expected 0", bs.o_ready);
    end
    bs.i_valid = 1'b0;
    lat = -1;
    r = 32'hDEAD_BEEF;
    for (int k = 5; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bs.o_valid) begin lat = k; r = bs.o_result; break; end
    end
    checks++;
    if (r !== 32'd14 || lat != 33) begin
      errors++;
      $display("FAIL busy_ignored got result=%h lat=%0d expected 0000000e lat=33", r, lat);
    end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat, seen;
    // Previous result from test_busy_ignored is 14 and must survive the kill.
    bs.i_valid = 1'b1; bs.i_op = 3'd0; bs.i_op1 = 32'd9; bs.i_op2 = 32'd9;
    @(posedge clk); #1;
    bs.i_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    bs.i_kill = 1'b1;
    @(posedge clk); #1;
    bs.i_kill = 1'b0;
    checks++;
    if (bs.o_ready !== 1'b1 || bs.o_valid !== 1'b0 || bs.o_result !== 32'd14) begin
      errors++;
      $display("FAIL kill_calc got ready=%b valid=%b result=%h expected 1 0 0000000e", bs.o_ready, bs.o_valid, bs.o_result);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bs.o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL kill_no_valid got %0d pulses expected 0", seen);
    end
    run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFD || lat != 33) begin
      errors++;
      $display("FAIL kill_next_op got result=%h lat=%0d expected fffffffd lat=33", r, lat);
    end
    // Kill landing in the DONE cycle masks the pulse.
    bs.i_valid = 1'b1; bs.i_op = 3'd5; bs.i_op1 = 32'd1; bs.i_op2 = 32'd0;
    @(posedge clk); #1;
    bs.i_valid = 1'b0;
    @(posedge clk); #1;
    bs.i_kill = 1'b1;
    #1;
    checks++;
    if (bs.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_done got valid=%b expected 0", bs.o_valid);
    end
    @(posedge clk); #1;
    bs.i_kill = 1'b0;
    checks++;
    if (bs.o_ready !== 1'b1 || bs.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_done_after got ready=%b valid=%b expected 1 0", bs.o_ready, bs.o_valid);
    end
  endtask

  task automatic test_reset_mid();
    bs.i_valid = 1'b1; bs.i_op = 3'd5; bs.i_op1 = 32'd1000; bs.i_op2 = 32'd3;
    @(posedge clk); #1;
    bs.i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bs.o_ready !== 1'b1 || bs.o_valid !== 1'b0 || bs.o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got ready=%b valid=%b result=%h expected 1 0 00000000", bs.o_ready, bs.o_valid, bs.o_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input bit fast, input int n);
    logic [2:0]  op;
    logic [31:0] a, b, r, ex;
    int lat, exp_lat;
    bit short_path;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      ex = ref_model(op, a, b);
      if (op[2])
        short_path = (b == 0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
      else
        short_path = fast;
      exp_lat = short_path ? 1 : 33;
      run_op(fast, op, a, b, r, lat);
      checks++;
      if (r !== ex || lat != exp_lat) begin
        errors++;
        $display("FAIL random_f%0d op=%0d a=%h b=%h got %h lat=%0d expected %h lat=%0d", fast, op, a, b, r, lat, ex, exp_lat);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bs.i_valid = 1'b0; bs.i_op = '0; bs.i_op1 = '0; bs.i_op2 = '0; bs.i_kill = 1'b0;
    bf.i_valid = 1'b0; bf.i_op = '0; bf.i_op1 = '0; bf.i_op2 = '0; bf.i_kill = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_mul();
    test_div();
    test_special();
    test_fast_mul();
    test_busy_ignored();
    test_kill();
    test_reset_mid();
    test_random(1'b0, 200);
    test_random(1'b1, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
